fp16_rdiv_seq: RTL and testbench

FP16_RDIV_SEQ -- requirements
Module: fp16_rdiv_seq

---
 rtl/fp16_rdiv_seq.sv | 112 +++++++++++
 tb/tb_fp16_rdiv_seq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fp16_rdiv_seq.sv
// Sequential FP16 divider: 12-step restoring mantissa division, one normalise step,
// truncating result, flush-to-zero on subnormals, no NaN output.
module fp16_rdiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] arg_0,
  input  logic [15:0] arg_1,
  input  logic        req_valid,
  output logic        req_ready,
  output logic [15:0] ret_0,
  output logic        ret_valid,
  input  logic        ret_ready
);

  // Handshake: a request transfers on a rising edge with req_valid && req_ready;
  // a result transfers on a rising edge with ret_valid && ret_ready. Neither
  // ready/valid is combinationally dependent on the other side.
  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t      state;
  logic        sign;
  logic [4:0]  e0, e1;
  logic [10:0] m0, m1;
  logic [11:0] r, q;
  logic [3:0]  cnt;

  logic        acc_sign;
  logic [4:0]  acc_e0, acc_e1;
  logic        r_ge;
  logic [11:0] r_sub;
  logic signed [6:0] e_base, e_n;
  logic [9:0]  frac;

  always_comb begin
    acc_sign = arg_0[15] ^ arg_1[15];
    acc_e0   = arg_0[14:10];
    acc_e1   = arg_1[14:10];
    r_ge     = (r >= {1'b0, m1});
    r_sub    = r_ge ? (r - {1'b0, m1}) : r;
    e_base   = $signed({2'b00, e0}) - $signed({2'b00, e1}) + 7'sd15;
    // A quotient below 1.0 needs one more shift, costing one exponent step.
    e_n      = q[11] ? e_base : (e_base - 7'sd1);
    frac     = q[11] ? q[10:1] : q[9:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      ret_valid <= 1'b0;
      ret_0     <= 16'h0000;
      sign      <= 1'b0;
      e0        <= 5'd0;
      e1        <= 5'd0;
      m0        <= 11'd0;
      m1        <= 11'd0;
      r         <= 12'd0;
      q         <= 12'd0;
      cnt       <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            sign      <= acc_sign;
            e0        <= acc_e0;
            e1        <= acc_e1;
            m0        <= {1'b1, arg_0[9:0]};
            m1        <= {1'b1, arg_1[9:0]};
            req_ready <= 1'b0;
            if (acc_e1 == 5'd0 || acc_e0 == 5'd31) begin
              ret_0     <= {acc_sign, 5'h1F, 10'h000};
              ret_valid <= 1'b1;
              state     <= DONE;
            end else if (acc_e0 == 5'd0 || acc_e1 == 5'd31) begin
              ret_0     <= {acc_sign, 15'h0000};
              ret_valid <= 1'b1;
              state     <= DONE;
            end else begin
              r     <= {1'b0, 1'b1, arg_0[9:0]};
              q     <= 12'd0;
              cnt   <= 4'd0;
              state <= DIV;
            end
          end
        end
        DIV: begin
          // r_sub < m1 < 2^11, so the bit shifted out is always zero.
          q   <= {q[10:0], r_ge};
          r   <= {r_sub[10:0], 1'b0};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd11) state <= NORM;
        end
        NORM: begin
          if (e_n >= 7'sd31)     ret_0 <= {sign, 5'h1F, 10'h000};
          else if (e_n <= 7'sd0) ret_0 <= {sign, 15'h0000};
          else                   ret_0 <= {sign, e_n[4:0], frac};
          ret_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (ret_ready) begin
            ret_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_rdiv_seq.sv
// Directed-vector bench for fp16_rdiv_seq: result values, result latency,
// backpressure hold, and reset abort.
module tb_fp16_rdiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] arg_0, arg_1;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] ret_0;
  logic        ret_valid;
  logic        ret_ready;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  fp16_rdiv_seq dut (
    .clk(clk), .rst(rst), .arg_0(arg_0), .arg_1(arg_1),
    .req_valid(req_valid), .req_ready(req_ready),
    .ret_0(ret_0), .ret_valid(ret_valid), .ret_ready(ret_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Present one request, wait for the result, and report value and latency
  // (latency 1 = result visible in the cycle right after the accept edge).
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] res, output int lat);
    @(negedge clk);
    arg_0 = a; arg_1 = b; req_valid = 1'b1;
    @(posedge clk);
    lat = 0;
    res = 16'hxxxx;
    while (lat < 40) begin
      @(negedge clk);
      req_valid = 1'b0;
      arg_0 = $urandom_range(0, 16'hFFFF);
      arg_1 = $urandom_range(0, 16'hFFFF);
      lat++;
      if (ret_valid) begin
        res = ret_0;
        break;
      end
    end
    if (!ret_valid) lat = -1;
  endtask

  task automatic release_result();
    ret_ready = 1'b1;
    @(negedge clk);
    ret_ready = 1'b0;
    check("ret_valid_after_release", {31'd0, ret_valid}, 32'd0);
    check("req_ready_after_release", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [15:0] res, held, exp_v;
    int lat;
    bit leak;

    vecs[0]  = '{16'h3C00, 16'h4000, 16'h3800, 14};
    vecs[1]  = '{16'h4200, 16'h4000, 16'h3E00, 14};
    vecs[2]  = '{16'h3C00, 16'h4200, 16'h3555, 14};
    vecs[3]  = '{16'hC000, 16'h4000, 16'hBC00, 14};
    vecs[4]  = '{16'h3C00, 16'h3C00, 16'h3C00, 14};
    vecs[5]  = '{16'h4000, 16'h3C00, 16'h4000, 14};
    vecs[6]  = '{16'h7800, 16'h0400, 16'h7C00, 14};
    vecs[7]  = '{16'h0400, 16'h7800, 16'h0000, 14};
    vecs[8]  = '{16'h3C00, 16'h0000, 16'h7C00, 1};
    vecs[9]  = '{16'h0000, 16'h4000, 16'h0000, 1};
    vecs[10] = '{16'h8000, 16'h7C00, 16'h8000, 1};
    vecs[11] = '{16'hBC00, 16'h0000, 16'hFC00, 1};

    rst = 1'b1; req_valid = 1'b0; ret_ready = 1'b0;
    arg_0 = 16'h0; arg_1 = 16'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_ret_valid", {31'd0, ret_valid}, 32'd0);
    check("reset_ret_0", {16'd0, ret_0}, 32'd0);

    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].q);
      issue(vecs[i].a, vecs[i].b, res, lat);
      exp_v = exp_q.pop_front();
      check($sformatf("vec%0d_ret_0", i), {16'd0, res}, {16'd0, exp_v});
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      release_result();
      check($sformatf("vec%0d_ret_0_held_idle", i), {16'd0, ret_0}, {16'd0, exp_v});
    end

    // Backpressure: hold the result while a competing request is presented.
    issue(16'h3C00, 16'h4000, res, lat);
    check("bp_ret_0", {16'd0, res}, 32'h3800);
    held = res;
    req_valid = 1'b1; arg_0 = 16'h4200; arg_1 = 16'h3C00;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", c), {14'd0, ret_valid, req_ready, ret_0},
            {14'd0, 1'b1, 1'b0, held});
    end
    req_valid = 1'b0;
    release_result();
    leak = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (ret_valid || !req_ready) leak = 1'b1;
    end
    check("bp_no_accept_during_hold", {31'd0, leak}, 32'd0);

    // Reset five cycles into the division, with a request presented during reset.
    @(negedge clk);
    arg_0 = 16'h4200; arg_1 = 16'h4000; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1; req_valid = 1'b1; arg_0 = 16'h3C00; arg_1 = 16'h0000;
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    check("abort_ret_valid", {31'd0, ret_valid}, 32'd0);
    check("abort_req_ready", {31'd0, req_ready}, 32'd1);
    check("abort_ret_0", {16'd0, ret_0}, 32'd0);
    leak = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (ret_valid || !req_ready) leak = 1'b1;
    end
    check("abort_no_result", {31'd0, leak}, 32'd0);

    // The block still works normally after the abort.
    issue(16'h3C00, 16'h4200, res, lat);
    check("post_abort_ret_0", {16'd0, res}, 32'h3555);
    check("post_abort_latency", lat, 14);
    release_result();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
